// File: rtl/img_pkg.sv
// ---------------------------------------------------------------------------
// img_pkg
// Shared definitions for the image buffer memory arbiter:
//   - default image / memory geometry (NPIX, AW, DW, RD_LAT)
//   - FSM state encoding
//   - read-tag record carried through the memory read-latency pipeline
// ---------------------------------------------------------------------------
package img_pkg;

  localparam int NPIX_DEF   = 784;  // 28x28 pixels
  localparam int AW_DEF     = 11;
  localparam int DW_DEF     = 16;
  localparam int RD_LAT_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_READY   = 2'd2
  } state_e;

  // Requester identity as carried in the tag (matches rr_arb2 gnt bit index).
  localparam logic WHO_A = 1'b0;
  localparam logic WHO_B = 1'b1;

  typedef struct packed {
    logic vld;  // a read was granted in this slot
    logic who;  // WHO_A / WHO_B
    logic oob;  // address was outside the image, return zero
  } rd_tag_t;

endpackage : img_pkg

// File: rtl/bmem_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter with combinational grant.
// Ports:
//   iCLK, iRST : clock, asynchronous active-low reset
//   req_i[1:0] : request vector (bit 0 = A, bit 1 = B)
//   gnt_o[1:0] : one-hot (or zero) grant, same cycle as the request
// The last-grant pointer resets to B so that A wins the first tie.
// ---------------------------------------------------------------------------
module rr_arb2 (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic last_b_q;  // 1: B was granted most recently

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_b_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      last_b_q <= 1'b1;
    end else if (|gnt_o) begin
      last_b_q <= gnt_o[1];
    end
  end

endmodule : rr_arb2

// File: rtl/bmem_arbiter.sv
// ---------------------------------------------------------------------------
// bmem_arbiter
// Owns a single-port image buffer memory. A capture stream fills it with one
// NPIX-pixel image; once complete, two readers (A = display, B = NN) share
// read access through a round-robin arbiter.
// Ports:
//   iCLK, iRST                     : clock, asynchronous active-low reset
//   iCAP_START, iCAP_VAL, iCAP_DATA: capture control / pixel stream
//   oDONE                          : buffer holds a complete image
//   iA_REN, iA_ADDR                : reader A request (held until granted)
//   oA_GNT, oA_DATA, oA_DVAL       : reader A grant / read return
//   iB_*, oB_*                     : same for reader B
//   oMEM_WEN, oMEM_REN, oMEM_ADDR  : memory controls
//   oMEM_WDATA, iMEM_RDATA         : memory data
// ---------------------------------------------------------------------------
module bmem_arbiter
  import img_pkg::*;
#(
  parameter int NPIX   = NPIX_DEF,
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iCAP_START,
  input  logic          iCAP_VAL,
  input  logic [DW-1:0] iCAP_DATA,
  output logic          oDONE,
  input  logic          iA_REN,
  input  logic [AW-1:0] iA_ADDR,
  output logic          oA_GNT,
  output logic [DW-1:0] oA_DATA,
  output logic          oA_DVAL,
  input  logic          iB_REN,
  input  logic [AW-1:0] iB_ADDR,
  output logic          oB_GNT,
  output logic [DW-1:0] oB_DATA,
  output logic          oB_DVAL,
  output logic          oMEM_WEN,
  output logic          oMEM_REN,
  output logic [AW-1:0] oMEM_ADDR,
  output logic [DW-1:0] oMEM_WDATA,
  input  logic [DW-1:0] iMEM_RDATA
);

  localparam logic [AW-1:0] LAST_PIX = AW'(NPIX - 1);
  localparam logic [AW:0]   NPIX_W   = (AW+1)'(NPIX);

  state_e        state_q;
  logic [AW-1:0] wr_cnt_q;
  logic          done_q;
  rd_tag_t       tag_q [RD_LAT];

  logic          wr_en;
  logic [1:0]    arb_req;
  logic [1:0]    arb_gnt;
  logic          gnt_any;
  logic [AW-1:0] gnt_addr;
  logic          gnt_oob;
  rd_tag_t       tag_d;
  rd_tag_t       tag_out;

  // --------------------------------------------------------------------------
  // Capture FSM
  // A start pulse while already capturing takes priority over a pixel in the
  // same cycle: the pixel is dropped and the counter restarts at 0.
  // --------------------------------------------------------------------------
  assign wr_en = (state_q == ST_CAPTURE) && iCAP_VAL && !iCAP_START;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q  <= ST_IDLE;
      wr_cnt_q <= '0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (iCAP_START) begin
            state_q  <= ST_CAPTURE;
            wr_cnt_q <= '0;
            done_q   <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (iCAP_START) begin
            wr_cnt_q <= '0;
          end else if (iCAP_VAL) begin
            if (wr_cnt_q == LAST_PIX) begin
              state_q  <= ST_READY;
              done_q   <= 1'b1;
              wr_cnt_q <= '0;
            end else begin
              wr_cnt_q <= wr_cnt_q + 1'b1;
            end
          end
        end
        ST_READY: begin
          if (iCAP_START) begin
            state_q  <= ST_CAPTURE;
            wr_cnt_q <= '0;
            done_q   <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          wr_cnt_q <= '0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign oDONE = done_q;

  // --------------------------------------------------------------------------
  // Read arbitration: only a complete image may be read, so requests are
  // masked (left pending) outside READY. Writes only happen in CAPTURE, which
  // keeps WEN and REN mutually exclusive by construction.
  // --------------------------------------------------------------------------
  assign arb_req = {iB_REN, iA_REN} & {2{state_q == ST_READY}};

  rr_arb2 u_rr_arb2 (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .req_i (arb_req),
    .gnt_o (arb_gnt)
  );

  assign gnt_any  = |arb_gnt;
  assign gnt_addr = arb_gnt[1] ? iB_ADDR : iA_ADDR;
  assign gnt_oob  = ({1'b0, gnt_addr} >= NPIX_W);

  assign oA_GNT     = arb_gnt[0];
  assign oB_GNT     = arb_gnt[1];
  assign oMEM_WEN   = wr_en;
  assign oMEM_REN   = gnt_any && !gnt_oob;
  assign oMEM_WDATA = wr_en ? iCAP_DATA : '0;

  always_comb begin
    oMEM_ADDR = '0;
    if (wr_en) begin
      oMEM_ADDR = wr_cnt_q;
    end else if (gnt_any) begin
      oMEM_ADDR = gnt_addr;
    end
  end

  // --------------------------------------------------------------------------
  // Read-return tag pipeline, aligned with the memory read latency. It is not
  // flushed on a capture start, so reads already granted still complete.
  // --------------------------------------------------------------------------
  always_comb begin
    tag_d     = '0;
    tag_d.vld = gnt_any;
    tag_d.who = arb_gnt[1] ? WHO_B : WHO_A;
    tag_d.oob = gnt_oob;
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      for (int i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= tag_d;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign tag_out = tag_q[RD_LAT-1];

  assign oA_DVAL = tag_out.vld && (tag_out.who == WHO_A);
  assign oB_DVAL = tag_out.vld && (tag_out.who == WHO_B);
  assign oA_DATA = (oA_DVAL && !tag_out.oob) ? iMEM_RDATA : '0;
  assign oB_DATA = (oB_DVAL && !tag_out.oob) ? iMEM_RDATA : '0;

endmodule : bmem_arbiter

// File: tb/tb_bmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bmem_arbiter
// Directed testbench for bmem_arbiter with a behavioural single-port memory
// of latency 2. Inputs change 1 ns after the rising edge; outputs are checked
// on the falling edge.
// ---------------------------------------------------------------------------
module tb_bmem_arbiter;

  localparam int AW = 11;
  localparam int DW = 16;

  logic          iCLK = 1'b0;
  logic          iRST;
  logic          iCAP_START, iCAP_VAL;
  logic [DW-1:0] iCAP_DATA;
  logic          oDONE;
  logic          iA_REN, oA_GNT, oA_DVAL;
  logic [AW-1:0] iA_ADDR;
  logic [DW-1:0] oA_DATA;
  logic          iB_REN, oB_GNT, oB_DVAL;
  logic [AW-1:0] iB_ADDR;
  logic [DW-1:0] oB_DATA;
  logic          oMEM_WEN, oMEM_REN;
  logic [AW-1:0] oMEM_ADDR;
  logic [DW-1:0] oMEM_WDATA, iMEM_RDATA;

  int n_checks = 0;
  int n_fail   = 0;
  int both_cnt = 0;

  always #5 iCLK = ~iCLK;

  bmem_arbiter dut (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .iCAP_START (iCAP_START),
    .iCAP_VAL   (iCAP_VAL),
    .iCAP_DATA  (iCAP_DATA),
    .oDONE      (oDONE),
    .iA_REN     (iA_REN),
    .iA_ADDR    (iA_ADDR),
    .oA_GNT     (oA_GNT),
    .oA_DATA    (oA_DATA),
    .oA_DVAL    (oA_DVAL),
    .iB_REN     (iB_REN),
    .iB_ADDR    (iB_ADDR),
    .oB_GNT     (oB_GNT),
    .oB_DATA    (oB_DATA),
    .oB_DVAL    (oB_DVAL),
    .oMEM_WEN   (oMEM_WEN),
    .oMEM_REN   (oMEM_REN),
    .oMEM_ADDR  (oMEM_ADDR),
    .oMEM_WDATA (oMEM_WDATA),
    .iMEM_RDATA (iMEM_RDATA)
  );

  // Memory model: reads without REN return a poison value so that the
  // out-of-range zeroing in the DUT is actually exercised.
  logic [DW-1:0] mem [2048];
  logic [DW-1:0] rd_p0, rd_p1;

  always @(posedge iCLK) begin
    if (oMEM_WEN) mem[oMEM_ADDR] <= oMEM_WDATA;
    rd_p0 <= oMEM_REN ? mem[oMEM_ADDR] : 16'hDEAD;
    rd_p1 <= rd_p0;
  end
  assign iMEM_RDATA = rd_p1;

  always @(negedge iCLK) begin
    if (oMEM_WEN && oMEM_REN) both_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  // Start pulse followed by n consecutive pixels with data = address.
  task automatic do_capture(input int n, input bit chk_en);
    iCAP_START = 1'b1;
    iCAP_VAL   = 1'b0;
    tick();
    iCAP_START = 1'b0;
    for (int i = 0; i < n; i++) begin
      iCAP_VAL  = 1'b1;
      iCAP_DATA = DW'(i);
      @(negedge iCLK);
      if (chk_en) begin
        check_eq("cap_wen", 32'(oMEM_WEN), 32'd1);
        check_eq("cap_addr", 32'(oMEM_ADDR), 32'(i));
        check_eq("cap_wdata", 32'(oMEM_WDATA), 32'(i));
        if (i == 100) check_eq("cap_no_gnt", 32'(oA_GNT), 32'd0);
        if (i == 783) check_eq("done_before_last", 32'(oDONE), 32'd0);
      end
      tick();
    end
    iCAP_VAL = 1'b0;
  endtask

  // Round-robin table: requests per cycle and expected grants / returns.
  int t_ar[8] = '{0, 1, 1, 1, 1, 0, 0, 0};
  int t_br[8] = '{1, 1, 1, 1, 1, 0, 0, 0};
  int t_ga[8] = '{0, 1, 0, 1, 0, 0, 0, 0};
  int t_gb[8] = '{1, 0, 1, 0, 1, 0, 0, 0};
  int t_va[8] = '{0, 0, 0, 1, 0, 1, 0, 0};
  int t_vb[8] = '{0, 0, 1, 0, 1, 0, 1, 0};

  initial begin
    iRST = 1'b0; iCAP_START = 1'b0; iCAP_VAL = 1'b0; iCAP_DATA = '0;
    iA_REN = 1'b0; iA_ADDR = '0; iB_REN = 1'b0; iB_ADDR = '0;

    // Reset values
    repeat (2) @(negedge iCLK);
    check_eq("rst_done", 32'(oDONE), 32'd0);
    check_eq("rst_gnt", 32'({oA_GNT, oB_GNT}), 32'd0);
    check_eq("rst_mem", 32'({oMEM_WEN, oMEM_REN}), 32'd0);
    check_eq("rst_dval", 32'({oA_DVAL, oB_DVAL}), 32'd0);
    iRST = 1'b1;
    tick();

    // Full capture with A requesting addr 7 throughout; granted on READY
    iA_REN = 1'b1; iA_ADDR = 11'd7;
    do_capture(784, 1'b1);
    @(negedge iCLK);
    check_eq("done_after_last", 32'(oDONE), 32'd1);
    check_eq("pend_gnt", 32'(oA_GNT), 32'd1);
    check_eq("pend_ren", 32'(oMEM_REN), 32'd1);
    check_eq("pend_addr", 32'(oMEM_ADDR), 32'd7);
    tick(); iA_REN = 1'b0;
    @(negedge iCLK);
    check_eq("pend_dval_early", 32'(oA_DVAL), 32'd0);
    tick();
    @(negedge iCLK);
    check_eq("pend_dval", 32'(oA_DVAL), 32'd1);
    check_eq("pend_data", 32'(oA_DATA), 32'd7);
    tick();

    // Single read of address 5
    iA_REN = 1'b1; iA_ADDR = 11'd5;
    @(negedge iCLK);
    check_eq("a5_gnt", 32'(oA_GNT), 32'd1);
    check_eq("a5_addr", 32'(oMEM_ADDR), 32'd5);
    tick(); iA_REN = 1'b0;
    tick();
    @(negedge iCLK);
    check_eq("a5_dval", 32'(oA_DVAL), 32'd1);
    check_eq("a5_data", 32'(oA_DATA), 32'd5);
    check_eq("a5_bdata_zero", 32'(oB_DATA), 32'd0);
    tick();

    // Round-robin with both readers requesting
    iA_ADDR = 11'd10; iB_ADDR = 11'd20;
    for (int c = 0; c < 8; c++) begin
      iA_REN = t_ar[c][0];
      iB_REN = t_br[c][0];
      @(negedge iCLK);
      check_eq($sformatf("rr%0d_ga", c), 32'(oA_GNT), 32'(t_ga[c]));
      check_eq($sformatf("rr%0d_gb", c), 32'(oB_GNT), 32'(t_gb[c]));
      check_eq($sformatf("rr%0d_va", c), 32'(oA_DVAL), 32'(t_va[c]));
      check_eq($sformatf("rr%0d_vb", c), 32'(oB_DVAL), 32'(t_vb[c]));
      check_eq($sformatf("rr%0d_da", c), 32'(oA_DATA), (t_va[c] != 0) ? 32'd10 : 32'd0);
      check_eq($sformatf("rr%0d_db", c), 32'(oB_DATA), (t_vb[c] != 0) ? 32'd20 : 32'd0);
      tick();
    end
    iA_REN = 1'b0; iB_REN = 1'b0;

    // Out-of-range read
    iB_REN = 1'b1; iB_ADDR = 11'd800;
    @(negedge iCLK);
    check_eq("oob_gnt", 32'(oB_GNT), 32'd1);
    check_eq("oob_ren", 32'(oMEM_REN), 32'd0);
    tick(); iB_REN = 1'b0;
    tick();
    @(negedge iCLK);
    check_eq("oob_dval", 32'(oB_DVAL), 32'd1);
    check_eq("oob_data", 32'(oB_DATA), 32'd0);
    tick();

    // Capture start right after a grant: the read still returns
    iA_REN = 1'b1; iA_ADDR = 11'd5;
    @(negedge iCLK);
    check_eq("fly_gnt", 32'(oA_GNT), 32'd1);
    tick(); iA_REN = 1'b0; iCAP_START = 1'b1;
    @(negedge iCLK);
    check_eq("fly_done_hold", 32'(oDONE), 32'd1);
    tick(); iCAP_START = 1'b0;
    iA_REN = 1'b1; iA_ADDR = 11'd9;
    @(negedge iCLK);
    check_eq("fly_dval", 32'(oA_DVAL), 32'd1);
    check_eq("fly_data", 32'(oA_DATA), 32'd5);
    check_eq("fly_done_clr", 32'(oDONE), 32'd0);
    check_eq("capt_no_gnt", 32'(oA_GNT), 32'd0);
    tick();

    // Reset pulse after 400 pixels
    do_capture(400, 1'b0);
    iCAP_VAL = 1'b1; iRST = 1'b0;
    @(negedge iCLK);
    check_eq("mrst_done", 32'(oDONE), 32'd0);
    check_eq("mrst_wen", 32'(oMEM_WEN), 32'd0);
    iRST = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge iCLK);
      check_eq($sformatf("post_rst%0d_wen", c), 32'(oMEM_WEN), 32'd0);
      check_eq($sformatf("post_rst%0d_gnt", c), 32'(oA_GNT), 32'd0);
      check_eq($sformatf("post_rst%0d_dval", c), 32'(oA_DVAL), 32'd0);
      check_eq($sformatf("post_rst%0d_done", c), 32'(oDONE), 32'd0);
    end
    tick();
    iCAP_VAL = 1'b0; iA_REN = 1'b0;

    // Reset with a read in flight: no return afterwards
    do_capture(784, 1'b0);
    iA_REN = 1'b1; iA_ADDR = 11'd3;
    @(negedge iCLK);
    check_eq("inf_done", 32'(oDONE), 32'd1);
    check_eq("inf_gnt", 32'(oA_GNT), 32'd1);
    tick(); iA_REN = 1'b0; iRST = 1'b0;
    @(negedge iCLK);
    check_eq("inf_dval0", 32'(oA_DVAL), 32'd0);
    iRST = 1'b1;
    tick();
    @(negedge iCLK);
    check_eq("inf_dval1", 32'(oA_DVAL), 32'd0);
    tick();
    @(negedge iCLK);
    check_eq("inf_dval2", 32'(oA_DVAL), 32'd0);
    tick();

    // Pointer resets to B: A wins the first tie
    do_capture(784, 1'b0);
    iA_REN = 1'b1; iA_ADDR = 11'd10;
    iB_REN = 1'b1; iB_ADDR = 11'd20;
    @(negedge iCLK);
    check_eq("tie_ga", 32'(oA_GNT), 32'd1);
    check_eq("tie_gb", 32'(oB_GNT), 32'd0);
    tick();
    iA_REN = 1'b0; iB_REN = 1'b0;
    repeat (3) tick();

    check_eq("wen_ren_excl", 32'(both_cnt), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_bmem_arbiter

// File: doc/bmem_arbiter.md
BMEM_ARBITER -- requirements
Module: bmem_arbiter

Interface
REQ-001 SHALL have parameter NPIX, default 784, meaning pixels per image (28x28).
REQ-002 SHALL have parameter AW, default 11, meaning memory address width.
REQ-003 SHALL have parameter DW, default 16, meaning memory data width.
REQ-004 SHALL have parameter RD_LAT, default 2, meaning fixed memory read latency in cycles.
REQ-005 SHALL have ports iCLK in 1 (clock) and iRST in 1: reset iRST, asynchronous, active-low; clock iCLK.
REQ-006 SHALL have ports iCAP_START in 1 (begin new capture) and iCAP_VAL in 1 (capture pixel valid).
REQ-007 SHALL have ports iCAP_DATA in DW (capture pixel) and oDONE out 1 (buffer holds a complete image).
REQ-008 SHALL have ports iA_REN in 1 and iA_ADDR in AW: display reader request and address, held until granted.
REQ-009 SHALL have ports oA_GNT out 1, oA_DATA out DW and oA_DVAL out 1: display grant, read data and data valid.
REQ-010 SHALL have ports iB_REN, iB_ADDR, oB_GNT, oB_DATA and oB_DVAL, identical to REQ-008/009, for the NN reader.
REQ-011 SHALL have ports oMEM_WEN out 1, oMEM_REN out 1 and oMEM_ADDR out AW: single-port memory controls.
REQ-012 SHALL have ports oMEM_WDATA out DW and iMEM_RDATA in DW: memory write and read data.

Function
REQ-013 SHALL implement FSM states IDLE (no valid image), CAPTURE and READY.
REQ-014 SHALL move IDLE->CAPTURE or READY->CAPTURE on iCAP_START; iCAP_START in CAPTURE SHALL restart the write counter at 0.
REQ-015 SHALL, in CAPTURE with iCAP_VAL=1, assert oMEM_WEN with oMEM_ADDR=wr_cnt and oMEM_WDATA=iCAP_DATA in the same cycle (combinational), then increment wr_cnt.
REQ-016 SHALL, on the write with wr_cnt=NPIX-1, go to READY the next cycle, set oDONE=1 and clear wr_cnt to 0.
REQ-017 SHALL ignore iCAP_VAL outside CAPTURE; oDONE SHALL clear in the cycle after iCAP_START.
REQ-018 SHALL grant no reads in IDLE or CAPTURE: oA_GNT=oB_GNT=0, and requests stay pending.
REQ-019 SHALL, in READY, grant at most one read per cycle, combinationally: oX_GNT=1, oMEM_REN=1, oMEM_ADDR=iX_ADDR.
REQ-020 SHALL grant a lone requester immediately; when both request, SHALL grant the one not granted last (round-robin); the last-grant pointer resets to B, so A wins the first tie.
REQ-021 SHALL carry a requester tag through an RD_LAT-deep shift register and assert exactly one of oA_DVAL/oB_DVAL RD_LAT cycles after the grant, with oX_DATA=iMEM_RDATA.
REQ-022 SHALL, for a granted address >= NPIX, not assert oMEM_REN and SHALL return data 0 with DVAL at the normal latency.
REQ-023 SHALL let reads granted before iCAP_START complete with DVAL even after entering CAPTURE.
REQ-024 SHALL hold oA_DATA/oB_DATA at 0 when the matching DVAL=0.
REQ-025 SHALL never assert oMEM_WEN and oMEM_REN in the same cycle.

Reset
REQ-026 SHALL, on iRST low, force state IDLE, wr_cnt 0, tag pipeline empty, pointer B, and all outputs 0, including oDONE.
REQ-027 SHALL discard in-flight reads on reset mid-operation (no DVAL after release) and require a new iCAP_START.

Structure
REQ-028 SHALL place the state enum, NPIX, AW, DW and RD_LAT defaults in shared package img_pkg.
REQ-029 SHALL implement the 2-requester round-robin in sub-module rr_arb2 (inputs req[1:0]; outputs gnt[1:0]; pointer update on grant).

Verification
REQ-030 SHALL test: iCAP_START, then 784 iCAP_VAL with data=address -> 784 writes to addresses 0..783, oDONE=1 one cycle after the last write.
REQ-031 SHALL test: READY, iA_REN with iA_ADDR=5 -> oA_GNT the same cycle, oA_DVAL 2 cycles later with oA_DATA=5.
REQ-032 SHALL test: both readers requesting continuously -> grants alternate A,B,A,B and each DVAL returns its own tag and data.
REQ-033 SHALL test: iB_ADDR=800 granted -> no oMEM_REN, oB_DVAL 2 cycles later with data 0.
REQ-034 SHALL test: iA_REN during CAPTURE -> no grant until READY, then granted; iCAP_START one cycle after a grant -> that DVAL still arrives.
REQ-035 SHALL test: iRST pulse after capturing 400 pixels -> IDLE, oDONE=0, no DVAL, reads blocked.
